// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lsu_pkg
// Description : Shared load/store size codes, FSM state type and lane helpers
//               for the load/store unit.
// Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

    localparam logic [2:0] LDST_B  = 3'b000;
    localparam logic [2:0] LDST_H  = 3'b001;
    localparam logic [2:0] LDST_W  = 3'b010;
    localparam logic [2:0] LDST_BU = 3'b100;
    localparam logic [2:0] LDST_HU = 3'b101;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } lsu_state_t;

    // Stores only exist in signed-size encodings; the unsigned codes are load-only.
    function automatic logic lsu_is_legal(input logic       we,
                                          input logic [2:0] size,
                                          input logic [1:0] off);
        logic ok;
        case (size)
            LDST_B, LDST_BU: ok = 1'b1;
            LDST_H, LDST_HU: ok = ~off[0];
            LDST_W:          ok = (off == 2'b00);
            default:         ok = 1'b0;
        endcase
        if (we && size[2]) begin
            ok = 1'b0;
        end
        return ok;
    endfunction

    function automatic logic [3:0] lsu_byte_en(input logic [2:0] size,
                                               input logic [1:0] off);
        logic [3:0] be;
        case (size[1:0])
            2'b00:   be = 4'b0001 << off;
            2'b01:   be = off[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] lsu_store_data(input logic [2:0]  size,
                                                   input logic [31:0] wd);
        logic [31:0] d;
        case (size[1:0])
            2'b00:   d = {4{wd[7:0]}};
            2'b01:   d = {2{wd[15:0]}};
            default: d = wd;
        endcase
        return d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_load_align.sv
`default_nettype none
// ============================================================================
// Module      : lsu_load_align
// Description : Selects the addressed byte/half lane of a read word and
//               sign- or zero-extends it to 32 bits.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [2:0]  i_size,
    input  logic [1:0]  i_offset,
    input  logic [31:0] i_rdata,
    output logic [31:0] o_result
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_rdata[7:0];
        case (i_offset)
            2'b00:   w_byte = i_rdata[7:0];
            2'b01:   w_byte = i_rdata[15:8];
            2'b10:   w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
    end

    assign w_half = i_offset[1] ? i_rdata[31:16] : i_rdata[15:0];

    always_comb begin
        o_result = i_rdata;
        case (i_size)
            LDST_B:  o_result = {{24{w_byte[7]}}, w_byte};
            LDST_BU: o_result = {24'h000000, w_byte};
            LDST_H:  o_result = {{16{w_half[15]}}, w_half};
            LDST_HU: o_result = {16'h0000, w_half};
            default: o_result = i_rdata;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/lsu_core_master.sv
`default_nettype none
// ============================================================================
// Module      : lsu_core_master
// Description : Load/store unit initiator: issues one data-memory access per
//               core request, stalls the core until ready, returns load data.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_core_master
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              core_req_i,
    input  logic              core_we_i,
    input  logic [2:0]        core_size_i,
    input  logic [ADDR_W-1:0] core_addr_i,
    input  logic [DATA_W-1:0] core_wd_i,
    output logic [DATA_W-1:0] core_rd_o,
    output logic              core_stall_o,
    output logic              core_err_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [3:0]        mem_be_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wd_o,
    input  logic [DATA_W-1:0] mem_rd_i,
    input  logic              mem_ready_i
);

    lsu_state_t        r_state;
    lsu_state_t        w_state_nxt;

    logic              r_we;
    logic [2:0]        r_size;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wd;

    logic              w_legal;
    logic              w_start;
    logic [DATA_W-1:0] w_load_data;

    assign w_legal = lsu_is_legal(core_we_i, core_size_i, core_addr_i[1:0]);
    assign w_start = (r_state == IDLE) && core_req_i && w_legal;

    lsu_load_align u_load_align (
        .i_size   (r_size),
        .i_offset (r_addr[1:0]),
        .i_rdata  (mem_rd_i),
        .o_result (w_load_data)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= IDLE;
            r_we    <= 1'b0;
            r_size  <= 3'b000;
            r_addr  <= '0;
            r_wd    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start) begin
                r_we   <= core_we_i;
                r_size <= core_size_i;
                r_addr <= core_addr_i;
                r_wd   <= core_wd_i;
            end
        end
    end

    // rst_i gates the IDLE path so nothing leaks out while reset is held.
    always_comb begin
        w_state_nxt  = r_state;
        mem_req_o    = 1'b0;
        mem_we_o     = 1'b0;
        mem_be_o     = 4'b0000;
        mem_addr_o   = '0;
        mem_wd_o     = '0;
        core_stall_o = 1'b0;
        core_err_o   = 1'b0;
        core_rd_o    = '0;
        case (r_state)
            IDLE: begin
                if (core_req_i && rst_i) begin
                    if (w_legal) begin
                        mem_req_o    = 1'b1;
                        mem_we_o     = core_we_i;
                        mem_be_o     = lsu_byte_en(core_size_i, core_addr_i[1:0]);
                        mem_addr_o   = core_addr_i;
                        mem_wd_o     = lsu_store_data(core_size_i, core_wd_i);
                        core_stall_o = 1'b1;
                        w_state_nxt  = WAIT;
                    end else begin
                        core_err_o = 1'b1;
                    end
                end
            end
            WAIT: begin
                mem_we_o   = r_we;
                mem_be_o   = lsu_byte_en(r_size, r_addr[1:0]);
                mem_addr_o = r_addr;
                mem_wd_o   = lsu_store_data(r_size, r_wd);
                if (mem_ready_i) begin
                    w_state_nxt = IDLE;
                    if (!r_we) begin
                        core_rd_o = w_load_data;
                    end
                end else begin
                    mem_req_o    = 1'b1;
                    core_stall_o = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

endmodule
`default_nettype wire
